seq_transmitter: RTL and testbench

SEQ_TRANSMITTER -- requirements
Module: seq_transmitter

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_shift_reg.sv | 29 ++
 rtl/seq_transmitter.sv | 143 ++++++++++++++
 tb/tb_seq_transmitter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared sequence package: transmitter/detector states,
// default frame geometry and the reference test key.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SEND,
        S_DONE
    } tx_state_t;

    localparam int KEY_LEN_DEF = 4;
    localparam int GAP_LEN_DEF = 2;

    localparam logic [3:0] TEST_KEY = 4'b1011;

    // A request for zero frames still sends one.
    function automatic logic [2:0] reps_eff(input logic [2:0] r);
        return (r == 3'd0) ? 3'd1 : r;
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load key register presenting its MSB;
// shifting rotates so the key is intact after a full frame.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         resetphase_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    // Load on accepted start, rotate left per transmitted bit.
    always_ff @(posedge clock or negedge resetphase_n) begin
        if (!resetphase_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], sr[W-1]};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/seq_transmitter.sv
// Framed serial key transmitter: GAP_LEN zeros then the key,
// MSB first, repeated for the latched number of frames.
module seq_transmitter
    import seq_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEF,
    parameter int GAP_LEN = GAP_LEN_DEF
) (
    input  logic               clock,
    input  logic               resetphase_n,
    input  logic               start,
    input  logic               abort,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic [2:0]         reps,
    output logic               seq,
    output logic               seq_valid,
    output logic               busy,
    output logic               done,
    output logic [2:0]         frame_cnt
);

    localparam int MAXL = (KEY_LEN > GAP_LEN) ? KEY_LEN : GAP_LEN;
    localparam int CW   = $clog2(MAXL);

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_LEN - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    reps_q, reps_n;
    logic [2:0]    fcnt_n;
    logic          seq_n, valid_n, busy_n, done_n;
    logic          load, shift, msb, more;

    seq_shift_reg #(.W(KEY_LEN)) u_sr (
        .clock        (clock),
        .resetphase_n (resetphase_n),
        .load         (load),
        .shift        (shift),
        .din          (key_in),
        .msb          (msb)
    );

    assign more = ({1'b0, frame_cnt} + 4'd1) < {1'b0, reps_q};

    // State, counters and all outputs are registered here.
    always_ff @(posedge clock or negedge resetphase_n) begin
        if (!resetphase_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            reps_q    <= '0;
            frame_cnt <= '0;
            seq       <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            reps_q    <= reps_n;
            frame_cnt <= fcnt_n;
            seq       <= seq_n;
            seq_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next state and next registered outputs; abort overrides all.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        reps_n  = reps_q;
        fcnt_n  = frame_cnt;
        seq_n   = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                    reps_n  = reps_eff(reps);
                    fcnt_n  = 3'd0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end
            S_GAP: begin
                busy_n  = 1'b1;
                valid_n = 1'b1;
                if (cnt == GAP_LAST) begin
                    state_n = S_SEND;
                    cnt_n   = '0;
                    seq_n   = msb;
                    shift   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SEND: begin
                busy_n = 1'b1;
                if (cnt == KEY_LAST) begin
                    fcnt_n = frame_cnt + 3'd1;
                    cnt_n  = '0;
                    if (more) begin
                        state_n = S_GAP;
                        valid_n = 1'b1;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n   = cnt + CW'(1);
                    seq_n   = msb;
                    valid_n = 1'b1;
                    shift   = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            fcnt_n  = frame_cnt;
            seq_n   = 1'b0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            shift   = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_transmitter.sv
// Directed bench for seq_transmitter with a
// behavioural 1011 detector on the serial loopback.
module tb_seq_transmitter;
    import seq_pkg::*;

    logic       clock = 1'b0;
    logic       resetphase_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] key_in = 4'b0;
    logic [2:0] reps = 3'd0;
    logic       seq, seq_valid, busy, done;
    logic [2:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    int done_cnt = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;
    int det_cnt = 0;

    logic [2:0] hist;
    logic       det;

    seq_transmitter dut (
        .clock        (clock),
        .resetphase_n (resetphase_n),
        .start        (start),
        .abort        (abort),
        .key_in       (key_in),
        .reps         (reps),
        .seq          (seq),
        .seq_valid    (seq_valid),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clock = ~clock;

    // Reference detector: flags a 1011 window on valid bits.
    always @(posedge clock or negedge resetphase_n) begin
        if (!resetphase_n) begin
            hist <= 3'b0;
            det  <= 1'b0;
        end else begin
            det <= seq_valid && ({hist, seq} == TEST_KEY);
            if (seq_valid) hist <= {hist[1:0], seq};
        end
    end

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (seq_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (det) det_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(negedge clock);
    endtask

    // Issue a start, then scramble key/reps to prove they were latched.
    task automatic issue(input logic [3:0] k, input logic [2:0] r);
        @(negedge clock);
        start  = 1'b1;
        key_in = k;
        reps   = r;
        @(negedge clock);
        start  = 1'b0;
        key_in = ~k;
        reps   = 3'd5;
    endtask

    task automatic run_tx(input logic [3:0] k, input logic [2:0] r,
                          input int nfr, input bit poke,
                          input bit exp_det);
        issue(k, r);
        for (int f = 0; f < nfr; f++) begin
            for (int g = 0; g < 2; g++) begin
                chk("gap_seq", 32'(seq), 32'd0);
                chk("gap_valid", 32'(seq_valid), 32'd1);
                if (poke && f == 1 && g == 0) begin
                    start  = 1'b1;
                    key_in = 4'b0000;
                    reps   = 3'd7;
                end
                adv();
                start = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                chk("key_bit", 32'(seq), 32'(k[3-i]));
                chk("key_valid", 32'(seq_valid), 32'd1);
                adv();
            end
            chk("frame_cnt", 32'(frame_cnt), 32'(f + 1));
            chk("det", 32'(det), 32'(exp_det));
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(seq_valid), 32'd0);
        chk("done_seq", 32'(seq), 32'd0);
        adv();
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd0);
        chk("end_fcnt", 32'(frame_cnt), 32'(nfr));
    endtask

    initial begin
        int d0, v0, b0, t0;

        #2;
        chk("rst_seq", 32'(seq), 32'd0);
        chk("rst_valid", 32'(seq_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clock);
        resetphase_n = 1'b1;
        adv();

        // 1011 x1: 00 1011, busy 7 cycles, one detection.
        d0 = done_cnt; b0 = busy_cnt; t0 = det_cnt;
        run_tx(4'b1011, 3'd1, 1, 1'b0, 1'b1);
        chk("t1_busy_len", 32'(busy_cnt - b0), 32'd7);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_det_cnt", 32'(det_cnt - t0), 32'd1);

        // reps=0 behaves as one frame.
        b0 = busy_cnt;
        run_tx(4'b1011, 3'd0, 1, 1'b0, 1'b1);
        chk("t2_busy_len", 32'(busy_cnt - b0), 32'd7);

        // 1100 x3 with a start poked mid-run.
        d0 = done_cnt; v0 = valid_cnt; b0 = busy_cnt; t0 = det_cnt;
        run_tx(4'b1100, 3'd3, 3, 1'b1, 1'b0);
        chk("t3_valid_len", 32'(valid_cnt - v0), 32'd18);
        chk("t3_busy_len", 32'(busy_cnt - b0), 32'd19);
        chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t3_det_cnt", 32'(det_cnt - t0), 32'd0);

        // 1001 x2 never trips the detector.
        t0 = det_cnt;
        run_tx(4'b1001, 3'd2, 2, 1'b0, 1'b0);
        chk("t4_det_cnt", 32'(det_cnt - t0), 32'd0);

        // Abort during the second key bit.
        d0 = done_cnt;
        issue(4'b1011, 3'd1);
        adv(); adv(); adv();
        chk("ab_bit1", 32'(seq), 32'd0);
        chk("ab_busy_pre", 32'(busy), 32'd1);
        abort = 1'b1;
        adv();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(seq_valid), 32'd0);
        chk("ab_fcnt", 32'(frame_cnt), 32'd0);
        adv(); adv();
        chk("ab_no_done", 32'(done_cnt - d0), 32'd0);

        // Abort wins over start in IDLE.
        v0 = valid_cnt;
        abort  = 1'b1;
        start  = 1'b1;
        key_in = 4'b1011;
        reps   = 3'd1;
        adv(); adv();
        chk("ab_idle_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        start = 1'b0;
        adv();
        chk("ab_idle_valid", 32'(valid_cnt - v0), 32'd0);

        // Asynchronous reset in the middle of SEND.
        d0 = done_cnt;
        issue(4'b1111, 3'd2);
        adv(); adv();
        chk("rs_pre_seq", 32'(seq), 32'd1);
        #2 resetphase_n = 1'b0;
        #1;
        chk("rs_seq", 32'(seq), 32'd0);
        chk("rs_valid", 32'(seq_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clock);
        resetphase_n = 1'b1;
        adv(); adv();
        chk("rs_idle_busy", 32'(busy), 32'd0);
        chk("rs_no_done", 32'(done_cnt - d0), 32'd0);

        // Fresh start after reset: two clean detections.
        t0 = det_cnt;
        run_tx(4'b1011, 3'd2, 2, 1'b0, 1'b1);
        chk("t5_det_cnt", 32'(det_cnt - t0), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
